my_divider: RTL and testbench

- Multi-cycle unsigned 32-bit restoring divider. It consumes `my_subtractor` as its per-iteration trial-subtract datapath.
- Sits beside the ALU in the MiniMIPS datapath and serves DIVU. Control issues a start pulse, stalls on busy, and captures the results on done.
- One quotient bit is resolved per clock, using a single `my_subtractor` instance.

---
 rtl/my_divider_pkg.sv | 15 +
 rtl/my_divider_if.sv | 24 ++
 rtl/my_subtractor.sv | 14 +
 rtl/my_divider.sv | 111 +++++++++++
 tb/tb_my_divider.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/my_divider_pkg.sv
// Shared constants and state encoding for the MiniMIPS multi-cycle divider.
package my_divider_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    localparam logic [WIDTH-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } div_state_t;

endpackage

// File: rtl/my_divider_if.sv
// Host-side request/result bundle for the divider; the host drives start and operands.
interface my_divider_if;
    import my_divider_pkg::*;

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/my_subtractor.sv
// 32-bit subtractor: res = a - b via a + ~b + c0; c=1 means no borrow (a >= b when c0=1).
module my_subtractor
    import my_divider_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c0,
    output logic [WIDTH-1:0] res,
    output logic             c
);

    assign {c, res} = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, c0};

endmodule

// File: rtl/my_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, serving DIVU.
//
//   state | meaning
//   IDLE  | waiting for start; operands sampled on the accepting edge
//   RUN   | one trial subtract per clock, 32 iterations
//   FIN   | done pulse for one cycle, results valid from here on
module my_divider
    import my_divider_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    my_divider_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    div_state_t       state, state_nxt;
    logic [WIDTH-1:0] r, q, m;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] quotient_q, remainder_q;
    logic             div_by_zero_q;

    logic [WIDTH-1:0] r_shift, sub_res, r_next, q_next;
    logic             sub_c, ok;

    assign r_shift = {r[WIDTH-2:0], q[WIDTH-1]};

    my_subtractor u_sub (
        .a   (r_shift),
        .b   (m),
        .c0  (1'b1),
        .res (sub_res),
        .c   (sub_c)
    );

    // The shifted-out msb means R' is really 33 bits and certainly exceeds M.
    assign ok     = r[WIDTH-1] | sub_c;
    assign r_next = ok ? sub_res : r_shift;
    assign q_next = {q[WIDTH-2:0], ok};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start)
                    state_nxt = (bus.divisor == '0) ? FIN : RUN;
            end
            RUN: begin
                bus.busy = 1'b1;
                if (count == LAST_ITER)
                    state_nxt = FIN;
            end
            FIN: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r             <= '0;
            q             <= '0;
            m             <= '0;
            count         <= '0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        m             <= bus.divisor;
                        q             <= bus.dividend;
                        r             <= '0;
                        count         <= '0;
                        div_by_zero_q <= 1'b0;
                        if (bus.divisor == '0) begin
                            quotient_q    <= DIV0_QUOTIENT;
                            remainder_q   <= bus.dividend;
                            div_by_zero_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r     <= r_next;
                    q     <= q_next;
                    count <= count + CNT_W'(1);
                    if (count == LAST_ITER) begin
                        quotient_q  <= q_next;
                        remainder_q <= r_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_my_divider.sv
// Directed bench for my_divider: expected results queued at issue, checked when done fires.
module tb_my_divider;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    my_divider_if bus ();

    my_divider dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Issue one request; returns just after the accepting edge with start dropped.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1; e.lat = 1;
        end else begin
            e.q = a / b; e.r = a % b; e.dz = 1'b0; e.lat = 33;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
    endtask

    // n0 = negedges already elapsed since the accept edge; ends at the negedge inside the done cycle.
    task automatic wait_check(input string tag, input int n0);
        int   n;
        exp_t e;
        n = n0;
        e = sb[0];
        do begin
            @(negedge clk);
            n++;
            if (n == 1 && e.lat > 1) chk({tag, "_busy_first"}, {31'd0, bus.busy}, 32'd1);
        end while (!bus.done && n < 60);
        e = sb.pop_front();
        chk({tag, "_done"},    {31'd0, bus.done}, 32'd1);
        chk({tag, "_latency"}, n, e.lat);
        chk({tag, "_busy_fin"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_quot"},    bus.quotient, e.q);
        chk({tag, "_rem"},     bus.remainder, e.r);
        chk({tag, "_dz"},      {31'd0, bus.div_by_zero}, {31'd0, e.dz});
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        #1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_quot", bus.quotient, 32'd0);
        chk("rst_rem",  bus.remainder, 32'd0);
        chk("rst_dz",   {31'd0, bus.div_by_zero}, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        run_op(32'd100, 32'd7);
        wait_check("basic", 0);
        @(negedge clk);
        chk("basic_done_pulse", {31'd0, bus.done}, 32'd0);
        repeat (3) @(negedge clk);
        chk("basic_hold_quot", bus.quotient, 32'd14);
        chk("basic_hold_rem",  bus.remainder, 32'd2);

        run_op(32'hFFFF_FFFF, 32'd1);
        wait_check("max_div1", 0);
        run_op(32'd5, 32'd9);
        wait_check("small_big", 0);

        run_op(32'hFFFF_FFFF, 32'h8000_0001);
        wait_check("msb_a", 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFE);
        wait_check("msb_b", 0);

        run_op(32'h1234_5678, 32'd0);
        wait_check("div0", 0);
        @(negedge clk);
        chk("div0_done_pulse", {31'd0, bus.done}, 32'd0);

        // A request landing mid-run must neither disturb nor queue behind the current one.
        run_op(32'd100, 32'd7);
        repeat (10) @(negedge clk);
        bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        wait_check("lockout", 11);
        run_op(32'd77, 32'd8);
        chk("b2b_done_low", {31'd0, bus.done}, 32'd0);
        wait_check("b2b", 0);
        repeat (2) @(negedge clk);
        chk("b2b_no_requeue", {31'd0, bus.busy}, 32'd0);

        run_op(32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
        chk("mid_rst_quot", bus.quotient, 32'd0);
        chk("mid_rst_rem",  bus.remainder, 32'd0);
        chk("mid_rst_dz",   {31'd0, bus.div_by_zero}, 32'd0);
        void'(sb.pop_front());
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        run_op(32'd9, 32'd3);
        wait_check("post_rst", 0);

        for (int i = 0; i < 4; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom >> $urandom_range(31, 0);
            if (b == 32'd0) b = 32'd3;
            run_op(a, b);
            wait_check("rand", 0);
        end

        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
